dsp_i2s_tx: RTL and testbench

Serial audio transmitter directly downstream of the S-DSP mixer. It accepts one signed 16-bit stereo sample pair per DSP sample period and serializes it onto a 3-wire I2S link (BCLK, LRCK, SDATA) for an external DAC. A one-entry holding buffer decouples the DSP's sample strobe from the serial frame boundary, and underrun and overrun conditions are flagged. With defaults, one serial frame is exactly 64 clocks, matching the DSP's 64-cycle sample period.

---
 rtl/dsp_audio_pkg.sv | 19 +
 rtl/dsp_i2s_tx_if.sv | 14 +
 rtl/dsp_i2s_clkgen.sv | 64 ++++++
 rtl/dsp_i2s_tx.sv | 111 +++++++++++
 tb/tb_dsp_i2s_tx.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dsp_audio_pkg.sv
// Shared constants and types for the S-DSP audio output path.
package dsp_audio_pkg;

    localparam int DSP_SAMPLE_WIDTH      = 16;
    localparam int DSP_CLOCKS_PER_SAMPLE = 64;
    localparam int DSP_FRAME_BITS        = 2 * DSP_SAMPLE_WIDTH;

    // One stereo sample pair as produced by the mixer; l occupies the upper half.
    typedef struct packed {
        logic signed [DSP_SAMPLE_WIDTH-1:0] l;
        logic signed [DSP_SAMPLE_WIDTH-1:0] r;
    } dsp_stereo_t;

    // System clocks per serial frame: two slots of width bits, two half-periods per bit.
    function automatic int dsp_frame_clocks(input int width, input int bclk_half);
        return 4 * width * bclk_half;
    endfunction

endpackage

// File: rtl/dsp_i2s_tx_if.sv
// Sample handshake between the DSP mixer (master) and the I2S transmitter (slave).
interface dsp_i2s_tx_if
    import dsp_audio_pkg::*;
#(
    parameter int SAMPLE_WIDTH = DSP_SAMPLE_WIDTH
);
    logic signed [SAMPLE_WIDTH-1:0] sample_l;
    logic signed [SAMPLE_WIDTH-1:0] sample_r;
    logic                           sample_valid;
    logic                           sample_ready;

    modport master (output sample_l, output sample_r, output sample_valid, input sample_ready);
    modport slave  (input sample_l, input sample_r, input sample_valid, output sample_ready);
endinterface

// File: rtl/dsp_i2s_clkgen.sv
// Bit-clock divider and frame bit counter for the I2S transmitter.
// Produces BCLK, registered LRCK, edge strobes (valid for the coming clock
// edge) and the frame-boundary strobe (falling edge where bit_idx wraps).
module dsp_i2s_clkgen
    import dsp_audio_pkg::*;
#(
    parameter int SAMPLE_WIDTH = DSP_SAMPLE_WIDTH,
    parameter int BCLK_HALF    = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    output logic bclk,
    output logic lrck,
    output logic fall,
    output logic rise,
    output logic boundary
);
    localparam int FRAME_BITS = 2 * SAMPLE_WIDTH;
    localparam int IDX_W      = $clog2(FRAME_BITS);
    localparam int DIV_W      = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;

    logic [DIV_W-1:0] div_cnt_reg;
    logic [IDX_W-1:0] bit_idx_reg;
    logic [IDX_W-1:0] bit_idx_next;
    logic             bclk_reg;
    logic             lrck_reg;
    logic             wrap;

    assign wrap     = enable && (div_cnt_reg == DIV_W'(BCLK_HALF - 1));
    assign rise     = wrap && !bclk_reg;
    assign fall     = wrap && bclk_reg;
    assign boundary = fall && (bit_idx_reg == IDX_W'(FRAME_BITS - 1));
    assign bclk     = bclk_reg;
    assign lrck     = lrck_reg;

    // Next bit position, wrapping at the end of the frame.
    always_comb begin
        bit_idx_next = bit_idx_reg + IDX_W'(1);
        if (bit_idx_reg == IDX_W'(FRAME_BITS - 1)) begin
            bit_idx_next = '0;
        end
    end

    // Divider, BCLK toggle and bit counter; disable holds everything at reset values.
    always_ff @(posedge clock) begin
        if (reset || !enable) begin
            div_cnt_reg <= '0;
            bit_idx_reg <= '0;
            bclk_reg    <= 1'b0;
            lrck_reg    <= 1'b0;
        end else begin
            div_cnt_reg <= wrap ? '0 : div_cnt_reg + DIV_W'(1);
            if (wrap) begin
                bclk_reg <= !bclk_reg;
            end
            if (fall) begin
                bit_idx_reg <= bit_idx_next;
                lrck_reg    <= (bit_idx_next >= IDX_W'(SAMPLE_WIDTH));
            end
        end
    end

endmodule

// File: rtl/dsp_i2s_tx.sv
// I2S transmitter for the S-DSP mixer output: one-entry holding buffer,
// frame shift register and underrun/overrun flags.
// Build option: DSP_I2S_LJ_EN selects left-justified framing (no one-BCLK
// data delay); undefined gives standard I2S.
module dsp_i2s_tx
    import dsp_audio_pkg::*;
#(
    parameter int SAMPLE_WIDTH = DSP_SAMPLE_WIDTH,
    parameter int BCLK_HALF    = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    dsp_i2s_tx_if.slave smp,
    output logic        i2s_bclk,
    output logic        i2s_lrck,
    output logic        i2s_sdata,
    output logic        frame_start,
    output logic        underrun,
    output logic        overrun
);
    localparam int FRAME_BITS = 2 * SAMPLE_WIDTH;

    logic                  fall_strobe;
    logic                  boundary_strobe;
    logic                  bclk_rise_unused;
    logic [FRAME_BITS-1:0] new_pair;
    logic [FRAME_BITS-1:0] buf_reg;
    logic [FRAME_BITS-1:0] last_reg;
    logic [FRAME_BITS-1:0] shift_reg;
    logic                  full_reg;
    logic                  frame_start_reg;
    logic                  underrun_reg;
    logic                  overrun_reg;

    dsp_i2s_clkgen #(
        .SAMPLE_WIDTH (SAMPLE_WIDTH),
        .BCLK_HALF    (BCLK_HALF)
    ) u_clkgen (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .bclk     (i2s_bclk),
        .lrck     (i2s_lrck),
        .fall     (fall_strobe),
        .rise     (bclk_rise_unused),
        .boundary (boundary_strobe)
    );

    assign new_pair         = {smp.sample_l, smp.sample_r};
    assign smp.sample_ready = !full_reg;
    assign frame_start      = frame_start_reg;
    assign underrun         = underrun_reg;
    assign overrun          = overrun_reg;

    // Holding buffer, last-sent pair and the one-cycle status flags. A strobe
    // landing on the boundary refills the buffer the drain just emptied.
    always_ff @(posedge clock) begin
        if (reset) begin
            buf_reg         <= '0;
            last_reg        <= '0;
            full_reg        <= 1'b0;
            frame_start_reg <= 1'b0;
            underrun_reg    <= 1'b0;
            overrun_reg     <= 1'b0;
        end else begin
            frame_start_reg <= boundary_strobe;
            underrun_reg    <= boundary_strobe && !full_reg;
            overrun_reg     <= smp.sample_valid && full_reg && !boundary_strobe;
            if (boundary_strobe && full_reg) begin
                last_reg <= buf_reg;
            end
            if (smp.sample_valid) begin
                buf_reg  <= new_pair;
                full_reg <= 1'b1;
            end else if (boundary_strobe) begin
                full_reg <= 1'b0;
            end
        end
    end

    // Frame shift register: load at the boundary (repeat last pair on underrun),
    // shift left on every other falling edge; MSB is the current data bit.
    always_ff @(posedge clock) begin
        if (reset || !enable) begin
            shift_reg <= '0;
        end else if (boundary_strobe) begin
            shift_reg <= full_reg ? buf_reg : last_reg;
        end else if (fall_strobe) begin
            shift_reg <= {shift_reg[FRAME_BITS-2:0], 1'b0};
        end
    end

`ifdef DSP_I2S_LJ_EN
    assign i2s_sdata = shift_reg[FRAME_BITS-1];
`else
    logic delay_reg;

    // One-BCLK data delay so the MSB follows the LRCK edge by one bit.
    always_ff @(posedge clock) begin
        if (reset || !enable) begin
            delay_reg <= 1'b0;
        end else if (fall_strobe) begin
            delay_reg <= shift_reg[FRAME_BITS-1];
        end
    end

    assign i2s_sdata = delay_reg;
`endif

endmodule

// File: tb/tb_dsp_i2s_tx.sv
// Self-checking bench for dsp_i2s_tx: a time-based frame model checked every
// cycle, a serial receiver that rebuilds words from the DUT pins, directed
// cases plus randomized strobes/enable/reset. Honors DSP_I2S_LJ_EN.
module tb_dsp_i2s_tx;
    import dsp_audio_pkg::*;

    localparam int W         = DSP_SAMPLE_WIDTH;
    localparam int FB        = DSP_FRAME_BITS;
    localparam int BH        = 1;
    localparam int FRAME_CLK = dsp_frame_clocks(W, BH);

    logic clock  = 1'b0;
    logic reset  = 1'b1;
    logic enable = 1'b0;
    logic i2s_bclk, i2s_lrck, i2s_sdata, frame_start, underrun, overrun;

    dsp_i2s_tx_if #(.SAMPLE_WIDTH(W)) smp_if ();

    dsp_i2s_tx #(.SAMPLE_WIDTH(W), .BCLK_HALF(BH)) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .smp         (smp_if),
        .i2s_bclk    (i2s_bclk),
        .i2s_lrck    (i2s_lrck),
        .i2s_sdata   (i2s_sdata),
        .frame_start (frame_start),
        .underrun    (underrun),
        .overrun     (overrun)
    );

    always #5 clock = ~clock;

    int n_cmp  = 0;
    int n_bad  = 0;
    logic cmp_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_t = 0;          // enabled clocks since (re)start
    logic        m_full = 1'b0;
    dsp_stereo_t m_buf = '0, m_last = '0, m_cur = '0, m_prev = '0, m_in;
    logic        e_fs = 1'b0, e_ur = 1'b0, e_or = 1'b0, m_bnd;

    initial forever begin
        @(posedge clock);
        m_in.l = smp_if.sample_l;
        m_in.r = smp_if.sample_r;
        if (reset) begin
            m_t = 0; m_full = 1'b0; m_buf = '0; m_last = '0; m_cur = '0; m_prev = '0;
            e_fs = 1'b0; e_ur = 1'b0; e_or = 1'b0;
        end else begin
            m_bnd = enable && (((m_t + 1) % FRAME_CLK) == 0);
            e_fs = m_bnd;
            e_ur = m_bnd && !m_full;
            e_or = smp_if.sample_valid && m_full && !m_bnd;
            if (m_bnd) begin
                m_prev = m_cur;
                m_cur  = m_full ? m_buf : m_last;
                if (m_full) m_last = m_buf;
                m_full = 1'b0;
            end
            if (smp_if.sample_valid) begin
                m_buf  = m_in;
                m_full = 1'b1;
            end
            if (enable) m_t++;
            else begin
                m_t = 0; m_cur = '0; m_prev = '0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    int   c_h, c_b;
    logic x_bclk, x_lrck, x_sd;

    initial forever begin
        @(negedge clock);
        if (cmp_on) begin
            c_h    = m_t / BH;
            x_bclk = (c_h % 2) == 1;
            c_b    = (c_h / 2) % FB;
            x_lrck = c_b >= W;
`ifdef DSP_I2S_LJ_EN
            x_sd = m_cur[FB-1-c_b];
`else
            x_sd = (c_b == 0) ? m_prev[0] : m_cur[FB-c_b];
`endif
            chk("bclk", i2s_bclk, x_bclk);
            chk("lrck", i2s_lrck, x_lrck);
            chk("sdata", i2s_sdata, x_sd);
            chk("frame_start", frame_start, e_fs);
            chk("underrun", underrun, e_ur);
            chk("overrun", overrun, e_or);
            chk("sample_ready", smp_if.sample_ready, !m_full);
        end
    end

    // ---------------- serial receiver on DUT pins ----------------
    logic [31:0] rx_words [0:15];
    logic [31:0] rx_sh = '0;
    logic        rx_pb = 1'b0, rx_pl = 1'b0;
    int          rx_n = 0;

    initial forever begin
        @(negedge clock);
        if (reset || !enable) begin
            rx_pb = 1'b0; rx_pl = 1'b0; rx_sh = '0; rx_n = 0;
        end else begin
            if (i2s_bclk && !rx_pb) begin
                if (!i2s_lrck && rx_pl && rx_n < 16) begin
`ifdef DSP_I2S_LJ_EN
                    rx_words[rx_n] = rx_sh;
`else
                    rx_words[rx_n] = {rx_sh[30:0], i2s_sdata};
`endif
                    rx_n++;
                end
                rx_sh = {rx_sh[30:0], i2s_sdata};
                rx_pl = i2s_lrck;
            end
            rx_pb = i2s_bclk;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_t(input int target);
        int n = 0;
        while (m_t != target && n < 5000) begin
            tick();
            n++;
        end
        if (m_t != target) chk("wait_t_timeout", m_t, target);
    endtask

    task automatic send(input logic [15:0] l, input logic [15:0] r);
        smp_if.sample_l     = l;
        smp_if.sample_r     = r;
        smp_if.sample_valid = 1'b1;
        $display("tx t=%0d L=%04h R=%04h", m_t, l, r);
        tick();
        smp_if.sample_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        smp_if.sample_l = '0; smp_if.sample_r = '0; smp_if.sample_valid = 1'b0;
        tick(); tick();
        cmp_on = 1'b1;
        tick();
        chk("rst_ready", smp_if.sample_ready, 1);
        chk("rst_bclk", i2s_bclk, 0);
        chk("rst_sdata", i2s_sdata, 0);
        chk("rst_underrun", underrun, 0);

        enable = 1'b1; reset = 1'b0;
        tick();
        chk("first_rise", i2s_bclk, 1);
        wait_t(63);  chk("fs_before_64", frame_start, 0);
        wait_t(64);  chk("fs_at_64", frame_start, 1); chk("ur_at_64", underrun, 1);

        wait_t(70);  send(16'h8001, 16'h7FFE);
        chk("ready_after_fill", smp_if.sample_ready, 0);
        wait_t(128); chk("fs_at_128", frame_start, 1); chk("ur_at_128", underrun, 0);
        chk("ready_after_drain", smp_if.sample_ready, 1);
`ifdef DSP_I2S_LJ_EN
        chk("lj_msb_at_lrck_fall", i2s_sdata, 1);
        chk("lj_lrck_at_128", i2s_lrck, 0);
`else
        chk("i2s_slot0", i2s_sdata, 0);
        wait_t(130); chk("i2s_msb_delayed", i2s_sdata, 1);
`endif

        wait_t(150); send(16'h1111, 16'h1111);
        wait_t(160); send(16'h2222, 16'h2222);
        chk("overrun_pulse", overrun, 1);

        wait_t(200); send(16'h00FF, 16'h00FF);
        wait_t(255); send(16'hFF00, 16'hFF00);
        chk("bnd_no_overrun", overrun, 0);
        chk("bnd_fs", frame_start, 1);
        chk("bnd_refill", smp_if.sample_ready, 0);

        wait_t(400);
        chk("rx_count", rx_n >= 6, 1);
        chk("rx_frame0", rx_words[0], 32'h0000_0000);
        chk("rx_frame1", rx_words[1], 32'h0000_0000);
        chk("rx_frame2", rx_words[2], 32'h8001_7FFE);
        chk("rx_frame3", rx_words[3], 32'h2222_2222);
        chk("rx_frame4", rx_words[4], 32'h00FF_00FF);
        chk("rx_frame5", rx_words[5], 32'hFF00_FF00);

        wait_t(450); send(16'h1234, 16'h5678);
        wait_t(468); reset = 1'b1;
        tick();
        chk("midrst_bclk", i2s_bclk, 0);
        chk("midrst_lrck", i2s_lrck, 0);
        chk("midrst_sdata", i2s_sdata, 0);
        chk("midrst_ready", smp_if.sample_ready, 1);
        tick(); reset = 1'b0;
        wait_t(63); chk("midrst_fs_63", frame_start, 0);
        wait_t(64); chk("midrst_fs_64", frame_start, 1); chk("midrst_ur_64", underrun, 1);

        wait_t(100); send(16'hAAAA, 16'h5555);
        enable = 1'b0;
        tick(); tick();
        chk("dis_bclk", i2s_bclk, 0);
        chk("dis_sdata", i2s_sdata, 0);
        chk("dis_buffer_kept", smp_if.sample_ready, 0);
        enable = 1'b1;
        wait_t(64); chk("reen_fs", frame_start, 1); chk("reen_ur", underrun, 0);

        for (int i = 0; i < 4000; i++) begin
            smp_if.sample_valid = ($urandom_range(0, 47) == 0);
            smp_if.sample_l     = 16'($urandom);
            smp_if.sample_r     = 16'($urandom);
            if ($urandom_range(0, 999) == 0) enable = 1'b0;
            else if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
            reset = ($urandom_range(0, 2999) == 0);
            if (smp_if.sample_valid)
                $display("tx t=%0d L=%04h R=%04h", m_t, smp_if.sample_l, smp_if.sample_r);
            tick();
        end
        smp_if.sample_valid = 1'b0; reset = 1'b0; enable = 1'b1;
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
